icebus_poll_master: RTL and testbench
=====================================

ICEBUS_POLL_MASTER -- requirements
Module: icebus_poll_master

Interface
REQ-001 SHALL have parameter NUM_NODES, default 8, number of polled nodes (1..32).
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 22, status payload length after magic and before the CRC, including the node-id byte (2..64).
REQ-003 SHALL have parameter MAX_RETRIES, default 2, re-polls of a node after a failed attempt (0..7).
REQ-004 SHALL have ports: clk input 1 clock; reset input 1, asynchronous, active-high.
REQ-005 SHALL have ports: node_enable input NUM_NODES, poll mask; node_id input 8*NUM_NODES, node n's id at [8n+7:8n].
REQ-006 SHALL have ports: poll_interval input 32, clk cycles from one poll start to the next; timeout_cycles input 32, response window.
REQ-007 SHALL have ports: tx_data output 8; tx_valid output 1; tx_ready input 1, byte sink handshake.
REQ-008 SHALL have ports: rx_data input 8; rx_valid input 1, one-cycle pulse per received byte.
REQ-009 SHALL have ports: status_valid output 1; status_node output $clog2(NUM_NODES) (min 1); status_payload output 8*PAYLOAD_BYTES, byte 0 at MSBs.
REQ-010 SHALL have ports: err_valid output 1; err_node output $clog2(NUM_NODES); err_code output 2 (1=timeout, 2=CRC, 3=id mismatch).
REQ-011 SHALL have ports: node_alive output NUM_NODES; busy output 1.

Function
REQ-012 SHALL use states IDLE, SEND_REQ, HUNT, RECV, CHECK, NEXT.
REQ-013 IDLE SHALL load a 32-bit interval counter with poll_interval, treating 0 as 1, then start a poll when the counter reaches 0 and node_enable is nonzero.
REQ-014 Node selection SHALL be round-robin from the last polled index+1, skip disabled nodes, and wrap NUM_NODES-1 to 0.
REQ-015 SEND_REQ SHALL emit 7 bytes, 1C E1 CE BB, id, crc_hi, crc_lo; each byte is transferred on a cycle with tx_valid and tx_ready both high.
REQ-016 tx_valid SHALL stay high with tx_data stable until accepted; tx_valid SHALL be low in all other states.
REQ-017 CRC SHALL be CRC-16 poly 0x1021, init 0xFFFF, MSB-first, no final XOR, over bytes after the magic and excluding the CRC; transmitted high byte first.
REQ-018 After the last request byte is accepted, SHALL enter HUNT and load the timeout counter with timeout_cycles (0 treated as 1).
REQ-019 The timeout counter SHALL decrement in HUNT and RECV; reaching 0 SHALL abort the attempt with err_code 1.
REQ-020 HUNT SHALL shift rx bytes into a 4-byte window and enter RECV on the cycle the window equals 1C EB 00 DA.
REQ-021 RECV SHALL store PAYLOAD_BYTES+2 bytes, computing CRC incrementally, then enter CHECK.
REQ-022 CHECK (one cycle) SHALL compare the CRC first, then payload byte 0 against the polled id.
REQ-023 On success, SHALL pulse status_valid for 1 cycle with status_node and status_payload (held until the next success), and SHALL set node_alive[n].
REQ-024 On failure, SHALL pulse err_valid with err_node and err_code; if attempts so far ≤ MAX_RETRIES, SHALL return to SEND_REQ for the same node.
REQ-025 When retries are exhausted, SHALL clear node_alive[n] and go to NEXT.
REQ-026 NEXT SHALL return to IDLE in 1 cycle.
REQ-027 rx bytes in IDLE and SEND_REQ SHALL be ignored, and the window SHALL clear on entry to HUNT.
REQ-028 A node disabled mid-poll SHALL finish its current attempt, with no retries.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 status_valid and err_valid SHALL never assert in the same cycle.

Reset
REQ-031 Reset SHALL force IDLE, with tx_valid, status_valid, err_valid and busy at 0.
REQ-032 Reset SHALL clear node_alive, status_payload, err_code, err_node and status_node to 0.
REQ-033 Reset SHALL set the last-polled index to NUM_NODES-1, so the first poll targets the lowest enabled node, and SHALL load the interval counter with 0.
REQ-034 Reset asserted mid-frame SHALL drop tx_valid immediately; the partial frame is not resumed.

Verification
REQ-035 CRC: request for id 0x31 -> bytes 1C E1 CE BB 31 + CRC matching a model of REQ-017; model self-check CRC("123456789") = 0x29B1.
REQ-036 Good response: node 2, id 0x05, valid frame, tx_ready random -> status_valid 1 cycle, status_node=2, node_alive[2]=1.
REQ-037 Timeout: no response, MAX_RETRIES=2, timeout_cycles=100 -> 3 requests, 3 err_valid with code 1, node_alive cleared.
REQ-038 Corrupt CRC once, then good -> err_code 2, then status_valid on the retry, node_alive=1.
REQ-039 Wrap/skip: node_enable=8'b1000_0010 -> poll order 1,7,1,7; node_enable=0 -> no tx_valid for 10*poll_interval.
REQ-040 Reset mid-RECV, then release -> outputs at reset values, first poll to lowest enabled node.

Source files
------------

// File: rtl/icebus_poll_master_if.sv
// Byte-level bus between the poll master and the line transceiver.
//   tx_data/tx_valid/tx_ready : request byte stream, valid/ready handshake
//   rx_data/rx_valid          : received bytes, one-cycle pulse per byte
// master modport is the poll master's view; slave is the transceiver's view.
interface icebus_poll_master_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output tx_data, output tx_valid, input tx_ready,
                  input rx_data, input rx_valid);
  modport slave  (input tx_data, input tx_valid, output tx_ready,
                  output rx_data, output rx_valid);
endinterface

// File: rtl/icebus_poll_master.sv
// Round-robin status poller for an ICEBUS segment.
// Every poll_interval cycles the next enabled node is sent a 7-byte request
// (magic 1C E1 CE BB, id, CRC-16); the reply is hunted by magic 1C EB 00 DA,
// followed by PAYLOAD_BYTES payload bytes and a 2-byte CRC. Failed attempts
// are retried up to MAX_RETRIES times.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   node_enable       : poll mask, one bit per node
//   node_id           : node n id at [8n+7:8n]
//   poll_interval     : cycles between poll starts (0 behaves as 1)
//   timeout_cycles    : response window per attempt (0 behaves as 1)
//   bus               : tx byte stream out, rx byte stream in
//   status_valid/node/payload : one-cycle success report, payload held
//   err_valid/node/code       : one-cycle failure report (1 timeout, 2 CRC, 3 id)
//   node_alive        : last known health per node
//   busy              : high whenever a poll is in progress
module icebus_poll_master #(
  parameter  int NUM_NODES     = 8,
  parameter  int PAYLOAD_BYTES = 22,
  parameter  int MAX_RETRIES   = 2,
  localparam int NW            = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_NODES-1:0]       node_enable,
  input  logic [8*NUM_NODES-1:0]     node_id,
  input  logic [31:0]                poll_interval,
  input  logic [31:0]                timeout_cycles,
  icebus_poll_master_if.master       bus,
  output logic                       status_valid,
  output logic [NW-1:0]              status_node,
  output logic [8*PAYLOAD_BYTES-1:0] status_payload,
  output logic                       err_valid,
  output logic [NW-1:0]              err_node,
  output logic [1:0]                 err_code,
  output logic [NUM_NODES-1:0]       node_alive,
  output logic                       busy
);

  typedef enum logic [2:0] {IDLE, SEND_REQ, HUNT, RECV, CHECK, NEXT} state_t;

  localparam logic [31:0] RESP_MAGIC = 32'h1CEB_00DA;
  localparam logic [3:0]  MAXR       = 4'(MAX_RETRIES);
  localparam logic [6:0]  PB         = 7'(PAYLOAD_BYTES);

  state_t                     state_q, state_d;
  logic [31:0]                ivl_q, ivl_d;
  logic [31:0]                tmo_q, tmo_d;
  logic [NW-1:0]              last_q, last_d;
  logic [NW-1:0]              cur_q, cur_d;
  logic [7:0]                 id_q, id_d;
  logic [6:0]                 cnt_q, cnt_d;
  logic [3:0]                 att_q, att_d;
  logic [31:0]                win_q, win_d;
  logic [15:0]                crc_q, crc_d;
  logic [15:0]                rxcrc_q, rxcrc_d;
  logic [8*PAYLOAD_BYTES-1:0] buf_q, buf_d;
  logic                       stat_v_q, stat_v_d;
  logic [NW-1:0]              stat_node_q, stat_node_d;
  logic [8*PAYLOAD_BYTES-1:0] stat_pay_q, stat_pay_d;
  logic                       err_v_q, err_v_d;
  logic [NW-1:0]              err_node_q, err_node_d;
  logic [1:0]                 err_code_q, err_code_d;
  logic [NUM_NODES-1:0]       alive_q, alive_d;

  logic                       sel_any;
  logic [NW-1:0]              sel_idx;
  int unsigned                k;
  logic [15:0]                req_crc;
  logic [7:0]                 tx_byte;
  logic                       fail;
  logic [1:0]                 fail_code;
  logic [31:0]                pi_eff, tc_eff;

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int unsigned b = 0; b < 8; b++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Round-robin pick: scanning offsets from farthest to nearest lets the
  // nearest enabled node after last_q win; offset NUM_NODES is last_q itself,
  // so a lone enabled node is re-polled.
  always_comb begin
    sel_any = |node_enable;
    sel_idx = last_q;
    k       = '0;
    for (int unsigned i = NUM_NODES; i >= 1; i--) begin
      k = (32'(last_q) + i) % NUM_NODES;
      if (node_enable[k]) sel_idx = NW'(k);
    end
  end

  always_comb begin
    req_crc = crc16_upd(16'hFFFF, id_q);
    case (cnt_q)
      7'd0:    tx_byte = 8'h1C;
      7'd1:    tx_byte = 8'hE1;
      7'd2:    tx_byte = 8'hCE;
      7'd3:    tx_byte = 8'hBB;
      7'd4:    tx_byte = id_q;
      7'd5:    tx_byte = req_crc[15:8];
      default: tx_byte = req_crc[7:0];
    endcase
  end

  assign pi_eff = (poll_interval == '0) ? 32'd1 : poll_interval;
  assign tc_eff = (timeout_cycles == '0) ? 32'd1 : timeout_cycles;

  always_comb begin
    state_d     = state_q;
    // Interval counter free-runs down to 0 in every state, so the reload at
    // poll start measures start-to-start spacing (loaded with interval-1).
    ivl_d       = (ivl_q != '0) ? ivl_q - 32'd1 : '0;
    tmo_d       = tmo_q;
    last_d      = last_q;
    cur_d       = cur_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    att_d       = att_q;
    win_d       = win_q;
    crc_d       = crc_q;
    rxcrc_d     = rxcrc_q;
    buf_d       = buf_q;
    stat_v_d    = 1'b0;
    stat_node_d = stat_node_q;
    stat_pay_d  = stat_pay_q;
    err_v_d     = 1'b0;
    err_node_d  = err_node_q;
    err_code_d  = err_code_q;
    alive_d     = alive_q;
    fail        = 1'b0;
    fail_code   = 2'd0;

    case (state_q)
      IDLE: begin
        if (ivl_q == '0 && sel_any) begin
          state_d = SEND_REQ;
          ivl_d   = pi_eff - 32'd1;
          cur_d   = sel_idx;
          last_d  = sel_idx;
          id_d    = node_id[8*sel_idx +: 8];
          cnt_d   = '0;
          att_d   = 4'd1;
        end
      end
      SEND_REQ: begin
        if (bus.tx_ready) begin
          if (cnt_q == 7'd6) begin
            state_d = HUNT;
            tmo_d   = tc_eff;
            win_d   = '0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      HUNT: begin
        tmo_d = tmo_q - 32'd1;
        if (tmo_q <= 32'd1) begin
          fail      = 1'b1;
          fail_code = 2'd1;
        end else if (bus.rx_valid) begin
          win_d = {win_q[23:0], bus.rx_data};
          if (win_d == RESP_MAGIC) begin
            state_d = RECV;
            cnt_d   = '0;
            crc_d   = 16'hFFFF;
          end
        end
      end
      RECV: begin
        tmo_d = tmo_q - 32'd1;
        if (tmo_q <= 32'd1) begin
          fail      = 1'b1;
          fail_code = 2'd1;
        end else if (bus.rx_valid) begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q < PB) begin
            buf_d = {buf_q[8*PAYLOAD_BYTES-9:0], bus.rx_data};
            crc_d = crc16_upd(crc_q, bus.rx_data);
          end else begin
            rxcrc_d = {rxcrc_q[7:0], bus.rx_data};
            if (cnt_q == PB + 7'd1) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (crc_q != rxcrc_q) begin
          fail      = 1'b1;
          fail_code = 2'd2;
        end else if (buf_q[8*PAYLOAD_BYTES-1 -: 8] != id_q) begin
          fail      = 1'b1;
          fail_code = 2'd3;
        end else begin
          stat_v_d       = 1'b1;
          stat_node_d    = cur_q;
          stat_pay_d     = buf_q;
          alive_d[cur_q] = 1'b1;
          state_d        = NEXT;
        end
      end
      NEXT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Shared failure path for timeout, CRC and id errors.
    if (fail) begin
      err_v_d    = 1'b1;
      err_node_d = cur_q;
      err_code_d = fail_code;
      if (att_q <= MAXR && node_enable[cur_q]) begin
        state_d = SEND_REQ;
        cnt_d   = '0;
        att_d   = att_q + 4'd1;
      end else begin
        alive_d[cur_q] = 1'b0;
        state_d        = NEXT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ivl_q       <= '0;
      tmo_q       <= '0;
      last_q      <= NW'(NUM_NODES - 1);
      cur_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      att_q       <= '0;
      win_q       <= '0;
      crc_q       <= '0;
      rxcrc_q     <= '0;
      buf_q       <= '0;
      stat_v_q    <= 1'b0;
      stat_node_q <= '0;
      stat_pay_q  <= '0;
      err_v_q     <= 1'b0;
      err_node_q  <= '0;
      err_code_q  <= '0;
      alive_q     <= '0;
    end else begin
      state_q     <= state_d;
      ivl_q       <= ivl_d;
      tmo_q       <= tmo_d;
      last_q      <= last_d;
      cur_q       <= cur_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      att_q       <= att_d;
      win_q       <= win_d;
      crc_q       <= crc_d;
      rxcrc_q     <= rxcrc_d;
      buf_q       <= buf_d;
      stat_v_q    <= stat_v_d;
      stat_node_q <= stat_node_d;
      stat_pay_q  <= stat_pay_d;
      err_v_q     <= err_v_d;
      err_node_q  <= err_node_d;
      err_code_q  <= err_code_d;
      alive_q     <= alive_d;
    end
  end

  assign bus.tx_valid   = (state_q == SEND_REQ);
  assign bus.tx_data    = tx_byte;
  assign busy           = (state_q != IDLE);
  assign status_valid   = stat_v_q;
  assign status_node    = stat_node_q;
  assign status_payload = stat_pay_q;
  assign err_valid      = err_v_q;
  assign err_node       = err_node_q;
  assign err_code       = err_code_q;
  assign node_alive     = alive_q;

endmodule

// File: tb/tb_icebus_poll_master.sv
// Scoreboard bench for icebus_poll_master: expected request bytes and
// status/error events are queued by the stimulus; a monitor pops and compares
// whenever the DUT hands over a byte or reports an event.
module tb_icebus_poll_master;
  localparam int NN = 8;
  localparam int PB = 4;
  localparam int MR = 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit            is_err;
    int            node;
    int            code;
    logic [8*PB-1:0] payload;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NN-1:0]     node_enable = '0;
  logic [8*NN-1:0]   node_id;
  logic [31:0]       poll_interval = 32'd400;
  logic [31:0]       timeout_cycles = 32'd100;
  logic              status_valid;
  logic [2:0]        status_node;
  logic [8*PB-1:0]   status_payload;
  logic              err_valid;
  logic [2:0]        err_node;
  logic [1:0]        err_code;
  logic [NN-1:0]     node_alive;
  logic              busy;

  icebus_poll_master_if bus();

  icebus_poll_master #(.NUM_NODES(NN), .PAYLOAD_BYTES(PB), .MAX_RETRIES(MR)) dut (
    .clk(clk), .reset(reset), .node_enable(node_enable), .node_id(node_id),
    .poll_interval(poll_interval), .timeout_cycles(timeout_cycles), .bus(bus),
    .status_valid(status_valid), .status_node(status_node),
    .status_payload(status_payload), .err_valid(err_valid), .err_node(err_node),
    .err_code(err_code), .node_alive(node_alive), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_tx[$];
  ev_t        exp_ev[$];
  bq_t        frame;
  int checks = 0, errors = 0;
  int tx_cnt = 0, req_seen = 0, tx_valid_cycles = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_model(input bq_t d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ d[i][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic push_req(input logic [7:0] id);
    bq_t q;
    logic [15:0] c;
    q.push_back(id);
    c = crc_model(q);
    exp_tx.push_back(8'h1C); exp_tx.push_back(8'hE1);
    exp_tx.push_back(8'hCE); exp_tx.push_back(8'hBB);
    exp_tx.push_back(id);
    exp_tx.push_back(c[15:8]); exp_tx.push_back(c[7:0]);
  endtask

  task automatic push_status(input int node, input logic [8*PB-1:0] pay);
    ev_t e;
    e.is_err = 1'b0; e.node = node; e.code = 0; e.payload = pay;
    exp_ev.push_back(e);
  endtask

  task automatic push_err(input int node, input int code);
    ev_t e;
    e.is_err = 1'b1; e.node = node; e.code = code; e.payload = '0;
    exp_ev.push_back(e);
  endtask

  task automatic build_frame(input logic [8*PB-1:0] pay, input bit corrupt);
    bq_t pl;
    logic [15:0] c;
    for (int i = PB - 1; i >= 0; i--) pl.push_back(pay[8*i +: 8]);
    c = crc_model(pl);
    frame.delete();
    frame.push_back(8'h1C); frame.push_back(8'hEB);
    frame.push_back(8'h00); frame.push_back(8'hDA);
    foreach (pl[i]) frame.push_back(pl[i]);
    frame.push_back(c[15:8]);
    frame.push_back(c[7:0] ^ (corrupt ? 8'h01 : 8'h00));
  endtask

  // Waits until the next whole request has been accepted; returns just after
  // the edge that moves the DUT into HUNT.
  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    req_seen++;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (tx_cnt >= 7 * req_seen) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_req: accepted %0d bytes, required %0d", tx_cnt, 7 * req_seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = frame[i];
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_ev_all();
    bit ok;
    ok = (exp_ev.size() == 0);
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #1;
      if (exp_ev.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_events: %0d outstanding, required 0", exp_ev.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // tx_ready changes just after the rising edge, so it is stable at sampling.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [7:0] eb;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.tx_valid) tx_valid_cycles++;
        if (bus.tx_valid && bus.tx_ready) begin
          tx_cnt++;
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx: got %02h required no transfer", bus.tx_data);
          end else begin
            eb = exp_tx.pop_front();
            chk("tx_byte", bus.tx_data, eb);
          end
        end
        if (status_valid && err_valid) begin
          checks++; errors++;
          $display("FAIL status_err_overlap: got both valid, required at most one");
        end
        if (status_valid || err_valid) begin
          if (exp_ev.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: got status=%0b err=%0b required none",
                     status_valid, err_valid);
          end else begin
            e = exp_ev.pop_front();
            chk("ev_is_err", err_valid, e.is_err);
            if (e.is_err) begin
              chk("err_node", err_node, e.node);
              chk("err_code", err_code, e.code);
            end else begin
              chk("status_node", status_node, e.node);
              chk("status_payload", status_payload, e.payload);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int  base;
    for (int n = 0; n < NN; n++) node_id[8*n +: 8] = 8'h40 + 8'(n);
    node_id[7:0]   = 8'h31;
    node_id[15:8]  = 8'h11;
    node_id[23:16] = 8'h05;
    node_id[63:56] = 8'h77;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;

    // CRC model self-checks, including a hand-worked single byte.
    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_model_123456789", crc_model(q), 16'h29B1);
    q = {8'h31};
    chk("crc_model_0x31", crc_model(q), 16'hC782);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_status_valid", status_valid, 1'b0);
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_node_alive", node_alive, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Node 0, id 0x31: basic request and good reply.
    push_req(8'h31);
    push_status(0, 32'h31A1A2A3);
    node_enable = 8'h01;
    wait_req();
    build_frame(32'h31A1A2A3, 1'b0);
    send_frame(frame.size());
    wait_ev_all();
    node_enable = 8'h00;
    chk("alive_after_n0", node_alive, 8'h01);
    chk("payload_held_n0", status_payload, 32'h31A1A2A3);

    // Node 2, id 0x05, random back-pressure.
    rand_ready = 1'b1;
    push_req(8'h05);
    push_status(2, 32'h05B1B2B3);
    node_enable = 8'h04;
    wait_req();
    build_frame(32'h05B1B2B3, 1'b0);
    send_frame(frame.size());
    wait_ev_all();
    node_enable = 8'h00;
    chk("alive_after_n2", node_alive, 8'h05);

    // Corrupt CRC once, then good reply on the retry.
    push_req(8'h05); push_err(2, 2);
    push_req(8'h05); push_status(2, 32'h05C1C2C3);
    node_enable = 8'h04;
    wait_req();
    build_frame(32'h05C1C2C3, 1'b1);
    send_frame(frame.size());
    wait_req();
    build_frame(32'h05C1C2C3, 1'b0);
    send_frame(frame.size());
    wait_ev_all();
    node_enable = 8'h00;
    chk("alive_after_crc_retry", node_alive, 8'h05);

    // No reply: 3 attempts, 3 timeouts, node 2 marked dead.
    push_req(8'h05); push_err(2, 1);
    push_req(8'h05); push_err(2, 1);
    push_req(8'h05); push_err(2, 1);
    node_enable = 8'h04;
    wait_req(); wait_req(); wait_req();
    wait_ev_all();
    node_enable = 8'h00;
    chk("alive_after_timeout", node_alive, 8'h01);

    // Id mismatch with valid CRC, then good reply.
    push_req(8'h11); push_err(1, 3);
    push_req(8'h11); push_status(1, 32'h11D1D2D3);
    node_enable = 8'h02;
    wait_req();
    build_frame(32'h12D1D2D3, 1'b0);
    send_frame(frame.size());
    wait_req();
    build_frame(32'h11D1D2D3, 1'b0);
    send_frame(frame.size());
    wait_ev_all();
    node_enable = 8'h00;
    chk("alive_after_id_retry", node_alive, 8'h03);

    // All nodes disabled: no traffic for 10 poll intervals.
    base = tx_valid_cycles;
    repeat (4000) @(posedge clk);
    #1;
    chk("disabled_no_tx", tx_valid_cycles - base, 0);
    chk("disabled_not_busy", busy, 1'b0);

    // Reset in the middle of a reply.
    push_req(8'h05);
    node_enable = 8'h04;
    wait_req();
    build_frame(32'h05E1E2E3, 1'b0);
    send_frame(6);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_tx_valid", bus.tx_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_node_alive", node_alive, '0);
    chk("midrst_status_payload", status_payload, '0);
    chk("midrst_status_node", status_node, '0);
    chk("midrst_err_node", err_node, '0);
    chk("midrst_err_code", err_code, '0);
    exp_tx.delete();
    exp_ev.delete();
    node_enable = 8'b1000_0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Wrap/skip order after reset: 1, 7, 1, 7.
    for (int r = 0; r < 4; r++) begin
      logic [7:0] id;
      int         nd;
      nd = (r % 2 == 0) ? 1 : 7;
      id = (r % 2 == 0) ? 8'h11 : 8'h77;
      push_req(id);
      push_status(nd, {id, 8'hF0 + 8'(r), 8'h5A, 8'hA5});
      wait_req();
      build_frame({id, 8'hF0 + 8'(r), 8'h5A, 8'hA5}, 1'b0);
      send_frame(frame.size());
      wait_ev_all();
    end
    node_enable = 8'h00;
    chk("alive_after_wrap", node_alive, 8'h82);
    chk("tx_queue_drained", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
